divclk_monitor: RTL and testbench
=================================

Name: divclk_monitor

Overview:
- Downstream consumer of the even frequency divider output; samples the divided clock as data in the `clk` domain.
- Produces single-cycle rise/fall strobes for logic that must not use the divided clock as a clock.
- Measures period and high time in `clk` cycles and reports lock against an expected period.
- Flags stalls, period mismatches and (optionally) duty-cycle faults.

Parameters:
- CNT_W, 8: width of period/high-time counters and results.
- LOCK_COUNT, 4: consecutive in-tolerance periods required to assert `locked`; range 1..15.
- TOL, 0: allowed |period − exp_period| in `clk` cycles.

Ports:
- clk  input  1  system clock.
- rstN  input  1  synchronous, active-high reset (asserted = 1, sampled on posedge `clk`).
- div_clk_i  input  1  divided clock, synchronous to `clk`.
- exp_period  input  CNT_W  expected period in `clk` cycles; must be held stable while not in reset.
- rise_pulse  output  1  one-cycle strobe on a detected rising edge.
- fall_pulse  output  1  one-cycle strobe on a detected falling edge.
- period  output  CNT_W  last measured period.
- high_time  output  CNT_W  last measured high time.
- meas_valid  output  1  one-cycle strobe when `period`/`high_time` update.
- locked  output  1  lock status.
- mismatch_err  output  1  sticky: an out-of-tolerance period was seen while locked.
- stall_err  output  1  sticky: counter saturated with no rising edge.
- duty_err  output  1  sticky duty fault; see Optional Feature.

Behaviour:
- Reset values: all outputs 0; `prev` = 0; counters 0; FSM = SEARCH.
- Edge detect:
  - `prev` <= `div_clk_i` every cycle.
  - `rise_pulse` <= `div_clk_i & ~prev`; `fall_pulse` <= `~div_clk_i & prev`.
  - Registered, so each strobe is high exactly 1 cycle, 1 cycle after the first `clk` edge that samples the new level.
- Counters: `pcnt` and `hcnt` count `clk` cycles and saturate at all-ones.
  - On a rise detection (internal `div_clk_i & ~prev`): `pcnt` <= 1, `hcnt` <= 1.
  - Otherwise `pcnt` increments; `hcnt` increments while `div_clk_i` is 1.
- FSM states: SEARCH, TRACK, LOCKED.
  - SEARCH: wait for a rise; on rise go to TRACK with `match_cnt` = 0. No measurement on this first rise.
  - TRACK / LOCKED, on each rise:
    - `period` <= `pcnt`, `high_time` <= `hcnt_at_fall`, `meas_valid` = 1 in the same cycle as `rise_pulse`.
    - In tolerance when |pcnt − exp_period| ≤ TOL, computed unsigned with CNT_W+1 bits.
  - TRACK: in-tolerance → `match_cnt`++; out of tolerance → `match_cnt` = 0. When `match_cnt` reaches LOCK_COUNT → LOCKED and `locked` = 1.
  - LOCKED: out-of-tolerance period → TRACK, `locked` = 0, `match_cnt` = 0, `mismatch_err` = 1.
  - Any state: `pcnt` saturated and no rise → SEARCH, `locked` = 0, `stall_err` = 1.
- `hcnt_at_fall` is captured on falling-edge detection. If no fall occurred in the period, it equals `hcnt` at the rise.
- Simultaneous saturation and rise: the rise wins. The measurement is taken as the saturated value, which is out of tolerance unless `exp_period` is all-ones.
- Sticky errors clear only on `rstN`.
- Reset mid-operation returns everything to reset values on the next `clk` edge.
- The strobes track the input even in SEARCH.

Optional Feature:
- Macro: DIVCLK_MONITOR_DUTY_CHECK_EN.
- Defined:
  - On each measurement in TRACK/LOCKED, check |2*high_time − period| ≤ 1, computed with CNT_W+2 bits.
  - Violation sets sticky `duty_err`. It does not affect lock.
- Undefined: `duty_err` is tied to 0 and no duty logic is synthesised.

Decomposition:
- Package `divclk_pkg`:
  - FSM state enum `divclk_state_e` {SEARCH, TRACK, LOCKED}.
  - Default constants for CNT_W, LOCK_COUNT and TOL.
  - Function `abs_diff`.
- One sub-module, `edge_strobe`: the `prev` register plus rise/fall strobe generation. It is reusable by other divided-clock consumers.

Test Plan:
- Divide-by-4 square wave (2 high, 2 low), exp_period = 4, LOCK_COUNT = 4, TOL = 0:
  - `rise_pulse` every 4 cycles.
  - `period` = 4, `high_time` = 2.
  - `locked` rises on the 5th rise strobe.
- Locked at /4, then one period of 6 → `locked` drops at that rise, `mismatch_err` = 1, re-lock after 4 more periods of 4.
- Input held at 0 for 255+ cycles with CNT_W = 8 → FSM returns to SEARCH, `stall_err` = 1, `locked` = 0.
- TOL = 1, alternating periods 4 and 5, exp_period = 4 → `locked` = 1 after 4 periods, no `mismatch_err`.
- `rstN` asserted for 1 cycle while locked → all outputs 0 the next cycle; re-lock requires 1 + LOCK_COUNT rises.
- With DIVCLK_MONITOR_DUTY_CHECK_EN: /4 wave at 1 high, 3 low → `duty_err` = 1 at the first measurement; at 2 high, 2 low → stays 0.

Source files
------------

// File: rtl/divclk_pkg.sv
// ============================================================================
// Module      : divclk_pkg
// Description : Shared types, default constants and helpers for divclk_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package divclk_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } divclk_state_e;

    localparam int c_DEF_CNT_W      = 8;
    localparam int c_DEF_LOCK_COUNT = 4;
    localparam int c_DEF_TOL        = 0;

    // Unsigned distance; callers zero-extend so no wrap can occur.
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

`default_nettype wire

// File: rtl/edge_strobe.sv
// ============================================================================
// Module      : edge_strobe
// Description : Samples a clk-synchronous level and emits registered one-cycle
//               rise/fall strobes plus same-cycle detect terms.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_strobe (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall,
    output logic o_rise_det,
    output logic o_fall_det
);

    logic r_prev;
    logic r_rise;
    logic r_fall;

    assign o_rise_det = i_sig & ~r_prev;
    assign o_fall_det = ~i_sig & r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= i_sig;
            r_rise <= o_rise_det;
            r_fall <= o_fall_det;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/divclk_monitor.sv
// ============================================================================
// Module      : divclk_monitor
// Description : Measures period/high time of a divided clock sampled as data,
//               tracks lock against exp_period and flags stall/mismatch faults.
//               Optional duty check enabled by DIVCLK_MONITOR_DUTY_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divclk_monitor
    import divclk_pkg::*;
#(
    parameter int CNT_W      = c_DEF_CNT_W,
    parameter int LOCK_COUNT = c_DEF_LOCK_COUNT,
    parameter int TOL        = c_DEF_TOL
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             div_clk_i,
    input  logic [CNT_W-1:0] exp_period,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             mismatch_err,
    output logic             stall_err,
    output logic             duty_err
);

    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       c_LOCK_TGT = 4'(LOCK_COUNT);
    localparam logic [31:0]      c_TOL      = 32'(TOL);

    logic             w_rise_det;
    logic             w_fall_det;
    logic             w_sat;
    logic             w_in_tol;
    logic [CNT_W-1:0] w_high;

    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_hcnt_at_fall;
    logic             r_fall_seen;

    divclk_state_e    r_state;
    logic [3:0]       r_match;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_meas_valid;
    logic             r_locked;
    logic             r_mismatch_err;
    logic             r_stall_err;

    edge_strobe u_edge_strobe (
        .clk        (clk),
        .rst        (rstN),
        .i_sig      (div_clk_i),
        .o_rise     (rise_pulse),
        .o_fall     (fall_pulse),
        .o_rise_det (w_rise_det),
        .o_fall_det (w_fall_det)
    );

    assign w_sat    = (r_pcnt == c_CNT_MAX);
    assign w_high   = r_fall_seen ? r_hcnt_at_fall : r_hcnt;
    assign w_in_tol = (abs_diff(32'(r_pcnt), 32'(exp_period)) <= c_TOL);

    always_ff @(posedge clk) begin
        if (rstN) begin
            r_pcnt         <= '0;
            r_hcnt         <= '0;
            r_hcnt_at_fall <= '0;
            r_fall_seen    <= 1'b0;
        end else if (w_rise_det) begin
            r_pcnt      <= c_CNT_ONE;
            r_hcnt      <= c_CNT_ONE;
            r_fall_seen <= 1'b0;
        end else begin
            if (!w_sat) begin
                r_pcnt <= r_pcnt + c_CNT_ONE;
            end
            if (div_clk_i && (r_hcnt != c_CNT_MAX)) begin
                r_hcnt <= r_hcnt + c_CNT_ONE;
            end
            if (w_fall_det) begin
                r_hcnt_at_fall <= r_hcnt;
                r_fall_seen    <= 1'b1;
            end
        end
    end

    // A rise always wins over saturation, so a 2^CNT_W-1 period is still measured.
    always_ff @(posedge clk) begin
        if (rstN) begin
            r_state        <= SEARCH;
            r_match        <= '0;
            r_period       <= '0;
            r_high_time    <= '0;
            r_meas_valid   <= 1'b0;
            r_locked       <= 1'b0;
            r_mismatch_err <= 1'b0;
            r_stall_err    <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            if (w_rise_det) begin
                if (r_state != SEARCH) begin
                    r_period     <= r_pcnt;
                    r_high_time  <= w_high;
                    r_meas_valid <= 1'b1;
                end
                case (r_state)
                    SEARCH: begin
                        r_state <= TRACK;
                        r_match <= '0;
                    end
                    TRACK: begin
                        if (w_in_tol) begin
                            r_match <= r_match + 4'd1;
                            if ((r_match + 4'd1) == c_LOCK_TGT) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_match <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!w_in_tol) begin
                            r_state        <= TRACK;
                            r_locked       <= 1'b0;
                            r_match        <= '0;
                            r_mismatch_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= SEARCH;
                        r_locked <= 1'b0;
                        r_match  <= '0;
                    end
                endcase
            end else if (w_sat) begin
                r_state     <= SEARCH;
                r_locked    <= 1'b0;
                r_match     <= '0;
                r_stall_err <= 1'b1;
            end
        end
    end

    assign period       = r_period;
    assign high_time    = r_high_time;
    assign meas_valid   = r_meas_valid;
    assign locked       = r_locked;
    assign mismatch_err = r_mismatch_err;
    assign stall_err    = r_stall_err;

`ifdef DIVCLK_MONITOR_DUTY_CHECK_EN
    logic [CNT_W+1:0] w_twice_high;
    logic             w_duty_ok;
    logic             r_duty_err;

    assign w_twice_high = {1'b0, w_high, 1'b0};
    assign w_duty_ok    = (abs_diff(32'(w_twice_high), 32'(r_pcnt)) <= 32'd1);

    always_ff @(posedge clk) begin
        if (rstN) begin
            r_duty_err <= 1'b0;
        end else if (w_rise_det && (r_state != SEARCH) && !w_duty_ok) begin
            r_duty_err <= 1'b1;
        end
    end

    assign duty_err = r_duty_err;
`else
    assign duty_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_divclk_monitor.sv
// Bench for divclk_monitor: two instances (TOL=0 and TOL=1) share one random
// stimulus stream and are compared every cycle against an edge-timestamp model.
`default_nettype none

module tb_divclk_monitor;

    localparam int CNT_W      = 8;
    localparam int LOCK_COUNT = 4;
    localparam int SAT        = 255;
`ifdef DIVCLK_MONITOR_DUTY_CHECK_EN
    localparam int DUTY_EXP = 1;
`else
    localparam int DUTY_EXP = 0;
`endif

    logic             clk       = 1'b0;
    logic             rstN      = 1'b1;
    logic             div_clk_i = 1'b0;
    logic [CNT_W-1:0] exp_period = 8'd4;

    logic             rp[2], fp[2], mv[2], lk[2], mm[2], st[2], du[2];
    logic [CNT_W-1:0] per[2], hi[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        divclk_monitor #(
            .CNT_W      (CNT_W),
            .LOCK_COUNT (LOCK_COUNT),
            .TOL        (g)
        ) u_dut (
            .clk          (clk),
            .rstN         (rstN),
            .div_clk_i    (div_clk_i),
            .exp_period   (exp_period),
            .rise_pulse   (rp[g]),
            .fall_pulse   (fp[g]),
            .period       (per[g]),
            .high_time    (hi[g]),
            .meas_valid   (mv[g]),
            .locked       (lk[g]),
            .mismatch_err (mm[g]),
            .stall_err    (st[g]),
            .duty_err     (du[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    // Model: timestamps of the last rise and of the fall inside the current period.
    int cyc = 0, anchor = 1, fall_at = 0;
    bit fall_seen = 1'b0, prev_m = 1'b0;
    int mode[2];   // 0 searching, 1 tracking, 2 locked
    int good[2];
    bit e_rise, e_fall, e_mv, e_stall, e_duty;
    bit e_lock[2], e_mm[2];
    int e_per = 0, e_high = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d at t=%0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit r, f;
        int el, mp, mh, d;
        cyc++;
        if (rstN) begin
            prev_m = 1'b0; anchor = cyc + 1; fall_seen = 1'b0;
            e_rise = 0; e_fall = 0; e_mv = 0; e_stall = 0; e_duty = 0;
            e_per = 0; e_high = 0;
            for (int k = 0; k < 2; k++) begin
                mode[k] = 0; good[k] = 0; e_lock[k] = 0; e_mm[k] = 0;
            end
            return;
        end
        r = div_clk_i && !prev_m;
        f = !div_clk_i && prev_m;
        prev_m = div_clk_i;
        el = cyc - anchor;
        if (el > SAT) el = SAT;
        e_rise = r; e_fall = f; e_mv = 0;
        if (r) begin
            mp = el;
            mh = fall_seen ? (fall_at - anchor) : el;
            if (mh > SAT) mh = SAT;
            if (mode[0] != 0) begin
                e_mv = 1; e_per = mp; e_high = mh;
`ifdef DIVCLK_MONITOR_DUTY_CHECK_EN
                d = 2 * mh - mp;
                if (d < 0) d = -d;
                if (d > 1) e_duty = 1;
`endif
            end
            d = mp - int'(exp_period);
            if (d < 0) d = -d;
            for (int k = 0; k < 2; k++) begin
                case (mode[k])
                    0: begin mode[k] = 1; good[k] = 0; end
                    1: begin
                        if (d <= k) begin
                            good[k]++;
                            if (good[k] == LOCK_COUNT) begin mode[k] = 2; e_lock[k] = 1; end
                        end else begin
                            good[k] = 0;
                        end
                    end
                    default: begin
                        if (d > k) begin mode[k] = 1; good[k] = 0; e_lock[k] = 0; e_mm[k] = 1; end
                    end
                endcase
            end
            anchor = cyc; fall_seen = 1'b0;
        end else begin
            if (f) begin fall_at = cyc; fall_seen = 1'b1; end
            if (el >= SAT) begin
                e_stall = 1;
                for (int k = 0; k < 2; k++) begin mode[k] = 0; good[k] = 0; e_lock[k] = 0; end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("rise_pulse",   k, rp[k],  e_rise);
                chk("fall_pulse",   k, fp[k],  e_fall);
                chk("meas_valid",   k, mv[k],  e_mv);
                chk("period",       k, per[k], e_per);
                chk("high_time",    k, hi[k],  e_high);
                chk("locked",       k, lk[k],  e_lock[k]);
                chk("mismatch_err", k, mm[k],  e_mm[k]);
                chk("stall_err",    k, st[k],  e_stall);
                chk("duty_err",     k, du[k],  e_duty);
            end
        end
    end

    task automatic drive(input bit v);
        @(negedge clk);
        div_clk_i = v;
    endtask

    task automatic wave(input int h, input int l, input int n);
        repeat (n) begin
            repeat (h) drive(1'b1);
            repeat (l) drive(1'b0);
        end
    endtask

    task automatic do_reset(input logic [CNT_W-1:0] ep);
        @(negedge clk);
        rstN = 1'b1; exp_period = ep; div_clk_i = 1'b0;
        @(negedge clk);
        rstN = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        check_en = 1'b1;
        do_reset(8'd4);
        chk("rst_locked", 0, lk[0], 0);
        chk("rst_period", 0, per[0], 0);
        chk("rst_stall",  0, st[0], 0);

        // /4 square wave: lock appears with the 5th rise strobe
        wave(2, 2, 4);
        chk("lit_lock_4rises", 0, lk[0], 0);
        chk("model_lock_4rises", 0, e_lock[0], 0);
        wave(2, 2, 1);
        chk("lit_lock_5rises", 0, lk[0], 1);
        chk("lit_lock_5rises", 1, lk[1], 1);
        chk("lit_period", 0, per[0], 4);
        chk("lit_high",   0, hi[0], 2);
        chk("model_period", 0, e_per, 4);
        chk("model_high",   0, e_high, 2);

        // one period of 6 while locked
        wave(3, 3, 1);
        wave(2, 2, 1);
        chk("lit_unlock", 0, lk[0], 0);
        chk("lit_mismatch", 0, mm[0], 1);
        chk("lit_period6", 0, per[0], 6);
        wave(2, 2, 4);
        chk("lit_relock", 0, lk[0], 1);
        chk("lit_mismatch_sticky", 0, mm[0], 1);

        // stall: input held low past saturation
        repeat (260) drive(1'b0);
        chk("lit_stall", 0, st[0], 1);
        chk("lit_stall_unlock", 0, lk[0], 0);
        chk("model_stall", 0, e_stall, 1);

        // reset while locked, then relock needs 1 + LOCK_COUNT rises
        do_reset(8'd4);
        wave(2, 2, 5);
        chk("lit_lock_pre_rst", 0, lk[0], 1);
        do_reset(8'd4);
        chk("lit_rst_locked", 0, lk[0], 0);
        chk("lit_rst_period", 0, per[0], 0);
        chk("lit_rst_high",   0, hi[0], 0);
        chk("lit_rst_mm",     0, mm[0], 0);
        wave(2, 2, 4);
        chk("lit_relock_4", 0, lk[0], 0);
        wave(2, 2, 1);
        chk("lit_relock_5", 0, lk[0], 1);

        // alternating 4/5: only the TOL=1 instance locks
        do_reset(8'd4);
        repeat (2) begin
            wave(2, 2, 1);
            wave(2, 3, 1);
        end
        wave(2, 2, 1);
        chk("lit_tol1_lock", 1, lk[1], 1);
        chk("lit_tol1_mm",   1, mm[1], 0);
        chk("lit_tol0_lock", 0, lk[0], 0);

        // duty: 2/2 is clean, 1/3 is a fault when the check is built in
        do_reset(8'd4);
        wave(2, 2, 3);
        chk("lit_duty_ok", 0, du[0], 0);
        wave(1, 3, 2);
        chk("lit_duty_bad", 0, du[0], DUTY_EXP);

        // randomized segments
        for (int i = 0; i < 60; i++) begin
            int sel, ep, h, l;
            sel = $urandom_range(0, 11);
            ep  = int'(exp_period);
            if (sel == 0) begin
                do_reset(8'($urandom_range(2, 8)));
            end else if (sel == 1) begin
                repeat ($urandom_range(250, 262)) drive(1'b0);
            end else if (sel == 2) begin
                h = $urandom_range(1, 3);
                wave(h, 255 - h + $urandom_range(0, 1), $urandom_range(1, 2));
            end else if (sel == 3) begin
                repeat ($urandom_range(255, 300)) drive(1'b1);
            end else if (sel <= 7) begin
                h = $urandom_range(1, (ep > 1) ? ep - 1 : 1);
                l = ep - h + $urandom_range(0, 1);
                if (l < 1) l = 1;
                wave(h, l, $urandom_range(1, 8));
            end else begin
                wave($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 6));
            end
        end
        wave(2, 2, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
